// File: rtl/ram_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_master: initiator-side controller for a single-port synchronous RAM.   |
// | Optional burst support via RAM_MASTER_BURST_EN.    Revision: 1.0           |
// +----------------------------------------------------------------------------+
module ram_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WRITE   = 3'd1;
  localparam logic [2:0] c_RD_WAIT = 3'd2;
  localparam logic [2:0] c_RD_CAP  = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_valid;
  logic                  w_accept;
  logic                  w_rsp_hs;
  logic                  w_last;

  assign w_accept = req_valid & req_ready;
  assign w_rsp_hs = r_rsp_valid & rsp_ready;

`ifdef RAM_MASTER_BURST_EN
  logic [ADDR_WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= req_len;
    end else if (!w_last && ((r_state == c_WRITE) || ((r_state == c_RESP) && w_rsp_hs))) begin
      r_count <= r_count - ADDR_WIDTH'(1);
    end
  end

  assign w_last = (r_count == '0);
`else
  logic w_unused_len;

  assign w_unused_len = ^req_len;
  assign w_last       = 1'b1;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_next = req_write ? c_WRITE : c_RD_WAIT;
        end
      end
      c_WRITE: begin
        if (w_last) begin
          w_state_next = c_IDLE;
        end
      end
      c_RD_WAIT: w_state_next = c_RD_CAP;
      c_RD_CAP:  w_state_next = c_RESP;
      c_RESP: begin
        if (w_rsp_hs) begin
          w_state_next = w_last ? c_IDLE : c_RD_WAIT;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    if (r_state == c_IDLE) begin
      req_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Datapath registers driving the RAM pins and the response channel
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_data;
            r_we    <= req_write;
          end
        end
        c_WRITE: begin
          if (w_last) begin
            r_we <= 1'b0;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        c_RD_CAP: begin
          r_rsp_data  <= ram_data_out;
          r_rsp_valid <= 1'b1;
        end
        c_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            if (!w_last) begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          r_we <= r_we;
        end
      endcase
    end
  end

  // Gating with reset keeps the RAM from committing the in-flight word on the reset edge.
  assign ram_write_enable = r_we & ~reset;
  assign ram_address      = r_addr;
  assign ram_data_in      = r_wdata;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_master: self-checking bench with a RAM model and a reference memory.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ram_master;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
`ifdef RAM_MASTER_BURST_EN
  localparam bit c_BURST = 1'b1;
`else
  localparam bit c_BURST = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          ram_write_enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_q;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] seed_val [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic          seed = 1'b0;

  always #5 clock = ~clock;

  ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_data         (req_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_q)
  );

  // 32x16 synchronous RAM with registered read
  always @(posedge clock) begin
    if (seed) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_val[i];
    end else if (ram_write_enable) begin
      mem[ram_address] <= ram_data_in;
    end
    ram_q <= mem[ram_address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_words(input logic [AW-1:0] len);
    return c_BURST ? int'(len) + 1 : 1;
  endfunction

  function automatic int mem_mismatches();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic wait_ready();
    for (int k = 0; k < 20 && !req_ready; k++) tick();
    check("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, {req_ready, busy, rsp_valid, rsp_data, ram_write_enable, ram_address, ram_data_in},
          {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 16'h0});
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [AW-1:0] len, input logic [DW-1:0] d);
    int n, we_cnt, busy_cnt;
    bit seq_ok;
    logic [AW-1:0] ea;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len; req_data = d;
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_data = DW'($urandom);
    n = eff_words(len); we_cnt = 0; busy_cnt = 0; seq_ok = 1'b1;
    for (int k = 0; k < 64 && busy; k++) begin
      busy_cnt++;
      if (ram_write_enable) begin
        ea = a + AW'(we_cnt);
        if (ram_address !== ea || ram_data_in !== d) seq_ok = 1'b0;
        we_cnt++;
      end
      tick();
    end
    check("wr_we_cycles", we_cnt, n);
    check("wr_busy_cycles", busy_cnt, n);
    check("wr_addr_seq", {31'd0, seq_ok}, 32'd1);
    for (int k = 0; k < n; k++) ref_mem[AW'(int'(a) + k)] = d;
    check("wr_mem", mem_mismatches(), 0);
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input int rdy_pct);
    int n, got, lat, busy_cnt;
    bit stable_ok, have_prev, rdy;
    logic [DW-1:0] prev;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len; req_data = DW'($urandom);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom);
    n = eff_words(len); got = 0; lat = -1; busy_cnt = 0;
    stable_ok = 1'b1; have_prev = 1'b0; prev = '0;
    for (int k = 1; k < 400 && busy; k++) begin
      busy_cnt++;
      if (rsp_valid) begin
        if (lat < 0) lat = k - 1;
        if (have_prev && rsp_data !== prev) stable_ok = 1'b0;
        rdy = ($urandom_range(99) < rdy_pct);
        rsp_ready = rdy;
        if (rdy) begin
          check("rd_data", {16'd0, rsp_data}, {16'd0, ref_mem[AW'(int'(a) + got)]});
          got++;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev = rsp_data;
        end
      end else begin
        rsp_ready = 1'($urandom);
        have_prev = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("rd_done", {31'd0, busy}, 32'd0);
    check("rd_words", got, n);
    check("rd_latency", lat, 2);
    check("rd_stable", {31'd0, stable_ok}, 32'd1);
    if (rdy_pct >= 100) check("rd_cycles", busy_cnt, 3 * n);
  endtask

  initial begin
    int accepts, hs_cnt, second_edge, last_hs;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;

    for (int i = 0; i < DEPTH; i++) begin
      seed_val[i] = DW'($urandom);
      ref_mem[i]  = seed_val[i];
    end
    seed = 1'b1;
    repeat (3) tick();
    seed = 1'b0;
    tick();
    check_reset_values("reset_values");
    reset = 1'b0;
    tick();

    // Single write then single read
    run_write(5'd5, 5'd0, 16'hBEEF);
    run_read(5'd5, 5'd0, 100);

    // Wrapping burst fill and read-back
    run_write(5'd30, 5'd3, 16'h1234);
    run_read(5'd30, 5'd3, 100);

    // Response backpressure held for 5 cycles
    wait_ready();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5; req_len = 5'd0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    hold_data = rsp_data;
    hold_addr = ram_address;
    check("bp_first", {rsp_valid, rsp_data}, {1'b1, 16'hBEEF});
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold", {rsp_valid, req_ready, rsp_data, ram_address}, {1'b1, 1'b0, hold_data, hold_addr});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release", {rsp_valid, req_ready}, {1'b0, 1'b1});

    // req_valid held through a burst read
    wait_ready();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd30; req_len = 5'd3;
    accepts = 0; hs_cnt = 0; second_edge = -1; last_hs = -1;
    for (int k = 0; k < 60 && accepts < 2; k++) begin
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) second_edge = cyc + 1;
      end
      if (rsp_valid && rsp_ready) begin
        check("cont_data", {16'd0, rsp_data}, {16'd0, ref_mem[AW'(30 + hs_cnt)]});
        hs_cnt++;
        last_hs = cyc + 1;
      end
      tick();
    end
    req_valid = 1'b0;
    check("cont_hs_before_2nd", hs_cnt, eff_words(5'd3));
    check("cont_accept_gap", second_edge - last_hs, 1);
    for (int k = 0; k < 60 && busy; k++) tick();
    rsp_ready = 1'b0;
    check("cont_drained", {31'd0, busy}, 32'd0);

    // Reset during the second cycle of a 4-word write at 8
    run_write(5'd9, 5'd0, 16'h5555);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd8; req_len = 5'd3; req_data = 16'hAAAA;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("mid_reset_values");
    reset = 1'b0;
    ref_mem[8] = 16'hAAAA;
    tick();
    check("mid_reset_addr8", {16'd0, mem[8]}, {16'd0, 16'hAAAA});
    check("mid_reset_addr9", {16'd0, mem[9]}, {16'd0, 16'h5555});
    check_reset_values("mid_reset_idle");

    // Long req_len: one word without bursts, eight with
    run_read(5'd2, 5'd7, 100);

    // Randomized traffic against the reference memory
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(1) == 1)
        run_write(AW'($urandom), AW'($urandom_range(7)), DW'($urandom));
      else
        run_read(AW'($urandom), AW'($urandom_range(7)), int'($urandom_range(90, 30)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
